// File: rtl/akp_pkg.sv
// Shared FSM type, default parameters and word-width helper for the AKP line sequencer.
package akp_pkg;

    localparam int AKP_NCH   = 6;
    localparam int AKP_DW    = 32;
    localparam int AKP_DEPTH = 4096;
    localparam int AKP_LW    = 12;
    localparam int AKP_PIPE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_READ  = 2'd2
    } akp_state_e;

    function automatic int akp_word_w(input int nch, input int dw);
        return nch * 2 * dw;
    endfunction

endpackage

// File: rtl/akp_sync_fifo.sv
// Single-clock FIFO with registered (one-cycle latency) read data and a synchronous flush.
module akp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [AW-1:0]    wr_addr;
    logic             wr_ok, rd_ok;

    // The extra MSB separates full from empty when the low pointer bits match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_data = rd_data_q;

    always_comb begin
        rd_ok     = rd_en && !empty && !flush;
        wr_ok     = wr_en && (flush || !full || rd_ok);
        wr_addr   = flush ? '0 : wptr_q[AW-1:0];
        rd_data_d = rd_ok ? mem[rptr_q[AW-1:0]] : rd_data_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = {{AW{1'b0}}, wr_en};
        end else begin
            rptr_d = rptr_q + {{AW{1'b0}}, rd_ok};
            wptr_d = wptr_q + {{AW{1'b0}}, wr_ok};
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/akp_line_sequencer.sv
// Buffers sample words in a FIFO and replays them as framed lines (sop/eop) after a start pulse.
module akp_line_sequencer
    import akp_pkg::*;
#(
    parameter int NCH   = AKP_NCH,
    parameter int DW    = AKP_DW,
    parameter int DEPTH = AKP_DEPTH,
    parameter int LW    = AKP_LW,
    parameter int PIPE  = AKP_PIPE
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                ink,
    input  logic                data_en,
    input  logic [NCH*2*DW-1:0] din,
    input  logic                start,
    input  logic [LW-1:0]       L_stroke,
    input  logic                mode,
    output logic [NCH*2*DW-1:0] dout,
    output logic                data_valid,
    output logic                sop,
    output logic                eop,
    output logic                fifo_empty,
    output logic                fifo_full,
    output logic                busy,
    output logic                ink_out,
    output logic                ovf,
    output logic                unf,
    output logic                abort
);
    localparam int WW = akp_word_w(NCH, DW);

    akp_state_e                state_q, state_d;
    logic [LW-1:0]             cnt_q, cnt_d, len_q, len_d;
    logic                      ovf_q, ovf_d, unf_q, unf_d, abort_q, abort_d;
    logic [PIPE:0]             vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, ink_sr_q, ink_sr_d;
    logic [PIPE-1:0][WW-1:0]   data_q, data_d;
    logic [WW-1:0]             fifo_rd_data;
    logic                      rd_en, last_rd;

    akp_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .flush   (ink),
        .wr_en   (data_en),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        rd_en   = (state_q == ST_READ) && !fifo_empty && !ink;
        last_rd = rd_en && (cnt_q == len_q);

        case (state_q)
            ST_IDLE: ;
            ST_ARMED: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    len_d   = L_stroke;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    cnt_d = cnt_q + LW'(1);
                    if (last_rd) begin
                        state_d = mode ? ST_ARMED : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ink overrides everything, including a coincident start.
        abort_d = ink && (state_q == ST_READ);
        if (ink) begin
            state_d = ST_ARMED;
        end

        ovf_d = ink ? 1'b0 : (ovf_q | (data_en & fifo_full & ~rd_en));
        unf_d = ink ? 1'b0 : (unf_q | ((state_q == ST_READ) & fifo_empty));

        // Control bits start one stage early to match the FIFO's registered read data.
        vld_d    = {vld_q[PIPE-1:0], rd_en};
        sop_d    = {sop_q[PIPE-1:0], rd_en && (cnt_q == '0)};
        eop_d    = {eop_q[PIPE-1:0], last_rd};
        ink_sr_d = {ink_sr_q[PIPE-1:0], ink};
        if (abort_d) begin
            vld_d = '0;
            sop_d = '0;
            eop_d = '0;
        end

        data_d[0] = fifo_rd_data;
        for (int i = 1; i < PIPE; i++) begin
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            abort_q  <= 1'b0;
            vld_q    <= '0;
            sop_q    <= '0;
            eop_q    <= '0;
            ink_sr_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            abort_q  <= abort_d;
            vld_q    <= vld_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            ink_sr_q <= ink_sr_d;
            data_q   <= data_d;
        end
    end

    assign dout       = data_q[PIPE-1];
    assign data_valid = vld_q[PIPE];
    assign sop        = sop_q[PIPE];
    assign eop        = eop_q[PIPE];
    assign busy       = (state_q != ST_IDLE);
    assign ink_out    = ink_sr_q[PIPE];
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_akp_line_sequencer.sv
// Scoreboard bench for akp_line_sequencer: a default-size DUT plus a DEPTH=4 DUT for FIFO-full cases.
module tb_akp_line_sequencer;
    import akp_pkg::*;

    localparam int WW   = AKP_NCH * 2 * AKP_DW;
    localparam int PIPE = AKP_PIPE;

    logic              clk = 1'b0;
    logic              clr, ink, data_en, start, mode;
    logic [WW-1:0]     din;
    logic [AKP_LW-1:0] l_stroke;

    logic [WW-1:0] dout, dout_s;
    logic data_valid, sop, eop, fifo_empty, fifo_full, busy, ink_out, ovf, unf, abort;
    logic data_valid_s, sop_s, eop_s, fifo_empty_s, fifo_full_s, busy_s, ink_out_s, ovf_s, unf_s, abort_s;

    akp_line_sequencer dut (
        .clk(clk), .clr(clr), .ink(ink), .data_en(data_en), .din(din), .start(start),
        .L_stroke(l_stroke), .mode(mode), .dout(dout), .data_valid(data_valid), .sop(sop),
        .eop(eop), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .busy(busy),
        .ink_out(ink_out), .ovf(ovf), .unf(unf), .abort(abort)
    );

    akp_line_sequencer #(.DEPTH(4)) dut_s (
        .clk(clk), .clr(clr), .ink(ink), .data_en(data_en), .din(din), .start(start),
        .L_stroke(l_stroke), .mode(mode), .dout(dout_s), .data_valid(data_valid_s), .sop(sop_s),
        .eop(eop_s), .fifo_empty(fifo_empty_s), .fifo_full(fifo_full_s), .busy(busy_s),
        .ink_out(ink_out_s), .ovf(ovf_s), .unf(unf_s), .abort(abort_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WW-1:0] data;
        logic          sop;
        logic          eop;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    logic mon_en = 1'b0;
    logic sel_small = 1'b0;
    int   passed = 0;
    int   total = 0;

    logic          m_v, m_s, m_e;
    logic [WW-1:0] m_d;
    exp_t          m_x;

    // Output monitor: every valid word must match the head of the scoreboard.
    always @(negedge clk) begin
        m_v = sel_small ? data_valid_s : data_valid;
        m_s = sel_small ? sop_s : sop;
        m_e = sel_small ? eop_s : eop;
        m_d = sel_small ? dout_s : dout;
        if (mon_en && m_v) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_word: got data=%0h sop=%0b eop=%0b at cyc %0d, required no valid output",
                         m_d, m_s, m_e, cyc);
            end else begin
                m_x = exp_q.pop_front();
                if (m_d !== m_x.data || m_s !== m_x.sop || m_e !== m_x.eop || (m_x.cyc >= 0 && cyc != m_x.cyc))
                    $display("FAIL word: got data=%0h sop=%0b eop=%0b cyc=%0d, required data=%0h sop=%0b eop=%0b cyc=%0d",
                             m_d, m_s, m_e, cyc, m_x.data, m_x.sop, m_x.eop, m_x.cyc);
                else
                    passed++;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ink();
        ink = 1'b1;
        step();
        ink = 1'b0;
    endtask

    task automatic write_words(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            data_en = 1'b1;
            din     = WW'(first + k);
            step();
        end
        data_en = 1'b0;
    endtask

    task automatic push_line(input int first, input int n, input int cyc0);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.data = WW'(first + k);
            x.sop  = (k == 0);
            x.eop  = (k == n - 1);
            x.cyc  = (cyc0 < 0) ? -1 : cyc0 + k;
            exp_q.push_back(x);
        end
    endtask

    // Start is sampled at the end of its cycle; the first read follows one cycle later, output PIPE+1 after that.
    task automatic do_start(input int len_m1, input int first, input int n, input bit timed);
        l_stroke = AKP_LW'(len_m1);
        start    = 1'b1;
        push_line(first, n, timed ? cyc + PIPE + 2 : -1);
        step();
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_drain: %0d words still outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end else begin
            passed++;
        end
        step(PIPE + 3);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({data_valid, sop, eop, fifo_full, busy, ink_out, ovf, unf, abort} !== 9'b0)
            $display("FAIL reset_flags: got %b, required 000000000",
                     {data_valid, sop, eop, fifo_full, busy, ink_out, ovf, unf, abort}); else passed++;
        total++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b, required 1", fifo_empty); else passed++;
        total++; if (dout !== '0) $display("FAIL reset_dout: got %0h, required 0", dout); else passed++;
    endtask

    task automatic test_basic();
        int c, s;
        sel_small = 1'b0; mon_en = 1'b1; mode = 1'b0;
        c = cyc;
        do_ink();
        step(PIPE - 1);
        @(negedge clk);
        total++; if (ink_out !== 1'b0) $display("FAIL basic_ink_out_early: got %b at cyc %0d, required 0", ink_out, cyc); else passed++;
        step();
        @(negedge clk);
        total++; if (ink_out !== 1'b1) $display("FAIL basic_ink_out: got %b at cyc %0d (ink at %0d), required 1", ink_out, cyc, c); else passed++;
        step();
        @(negedge clk);
        total++; if (ink_out !== 1'b0) $display("FAIL basic_ink_out_late: got %b, required 0", ink_out); else passed++;
        write_words(0, 8);
        s = cyc;
        do_start(7, 0, 8, 1'b1);
        step(7);
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_last_read: got %b at cyc %0d, required 1", busy, cyc - s); else passed++;
        step();
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b, required 0", busy); else passed++;
        drain("basic", 20);
        total++; if ({ovf, unf} !== 2'b00) $display("FAIL basic_flags: got ovf=%b unf=%b, required 0 0", ovf, unf); else passed++;
        total++; if (fifo_empty !== 1'b1) $display("FAIL basic_empty: got %b, required 1", fifo_empty); else passed++;
    endtask

    task automatic test_start_rules();
        write_words(8'h33, 1);
        l_stroke = '0; start = 1'b1; step(); start = 1'b0;
        step(PIPE + 3);
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL idle_start_ignored: busy=%b, required 0", busy); else passed++;
        step();
        ink = 1'b1; start = 1'b1; data_en = 1'b1; din = WW'(8'h77);
        step();
        ink = 1'b0; start = 1'b0; data_en = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL ink_start_armed: busy=%b, required 1", busy); else passed++;
        total++; if (fifo_empty !== 1'b0) $display("FAIL ink_write_word0: fifo_empty=%b, required 0", fifo_empty); else passed++;
        step(PIPE + 3);
        do_start(0, 8'h77, 1, 1'b1);
        drain("lstroke0", 15);
        total++; if (busy !== 1'b0 || fifo_empty !== 1'b1)
            $display("FAIL lstroke0_end: busy=%b fifo_empty=%b, required 0 1", busy, fifo_empty); else passed++;
    endtask

    task automatic test_underrun();
        do_ink();
        write_words(0, 3);
        do_start(5, 0, 6, 1'b0);
        for (int k = 3; k < 6; k++) begin
            write_words(k, 1);
            step(3);
        end
        drain("underrun", 30);
        total++; if (unf !== 1'b1) $display("FAIL underrun_unf: got %b, required 1", unf); else passed++;
        total++; if (busy !== 1'b0 || ovf !== 1'b0) $display("FAIL underrun_end: busy=%b ovf=%b, required 0 0", busy, ovf); else passed++;
    endtask

    task automatic test_abort();
        int abort_cnt, eop_cnt;
        do_ink();
        @(negedge clk);
        total++; if (unf !== 1'b0) $display("FAIL ink_clears_unf: got %b, required 0", unf); else passed++;
        write_words(0, 8);
        l_stroke = AKP_LW'(7); start = 1'b1; step(); start = 1'b0;
        step(2);
        ink = 1'b1; step(); ink = 1'b0;
        @(negedge clk);
        total++; if (abort !== 1'b1) $display("FAIL abort_pulse: got %b, required 1", abort); else passed++;
        total++; if (busy !== 1'b1 || fifo_empty !== 1'b1)
            $display("FAIL abort_armed_empty: busy=%b fifo_empty=%b, required 1 1", busy, fifo_empty); else passed++;
        abort_cnt = 1; eop_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            if (abort) abort_cnt++;
            if (eop) eop_cnt++;
        end
        total++; if (abort_cnt !== 1) $display("FAIL abort_once: got %0d pulses, required 1", abort_cnt); else passed++;
        total++; if (eop_cnt !== 0) $display("FAIL abort_no_eop: got %0d eops, required 0", eop_cnt); else passed++;
    endtask

    task automatic test_overflow();
        sel_small = 1'b1;
        do_ink();
        write_words(0, 6);
        @(negedge clk);
        total++; if (fifo_full_s !== 1'b1 || ovf_s !== 1'b1)
            $display("FAIL ovf_set: fifo_full=%b ovf=%b, required 1 1", fifo_full_s, ovf_s); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL ovf_deep_fifo: got %b, required 0", ovf); else passed++;
        do_start(3, 0, 4, 1'b1);
        drain("overflow", 20);
        total++; if (ovf_s !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", ovf_s); else passed++;
        total++; if (fifo_empty_s !== 1'b1) $display("FAIL ovf_dropped: fifo_empty=%b, required 1", fifo_empty_s); else passed++;
    endtask

    task automatic test_full_rw();
        do_ink();
        write_words(0, 4);
        @(negedge clk);
        total++; if (fifo_full_s !== 1'b1 || ovf_s !== 1'b0)
            $display("FAIL full_rw_pre: fifo_full=%b ovf=%b, required 1 0", fifo_full_s, ovf_s); else passed++;
        do_start(5, 0, 6, 1'b0);
        write_words(4, 2);
        drain("full_rw", 20);
        total++; if (ovf_s !== 1'b0) $display("FAIL full_rw_no_ovf: got %b, required 0", ovf_s); else passed++;
        sel_small = 1'b0;
    endtask

    task automatic test_continuous();
        mode = 1'b1;
        do_ink();
        write_words(0, 16);
        do_start(7, 0, 8, 1'b1);
        step(19);
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL cont_armed: busy=%b, required 1", busy); else passed++;
        do_start(7, 8, 8, 1'b1);
        drain("continuous", 30);
        total++; if (busy !== 1'b1 || unf !== 1'b0 || fifo_empty !== 1'b1)
            $display("FAIL cont_end: busy=%b unf=%b fifo_empty=%b, required 1 0 1", busy, unf, fifo_empty); else passed++;
        mode = 1'b0;
    endtask

    task automatic test_clr_mid_read();
        do_ink();
        write_words(0, 8);
        mon_en = 1'b0;
        l_stroke = AKP_LW'(7); start = 1'b1; step(); start = 1'b0;
        step(4);
        @(negedge clk);
        total++; if (data_valid !== 1'b1) $display("FAIL clr_pre_valid: got %b, required 1", data_valid); else passed++;
        #2 clr = 1'b1;
        #1;
        total++; if ({data_valid, sop, eop, fifo_full, busy, ink_out, ovf, unf, abort} !== 9'b0 || dout !== '0)
            $display("FAIL clr_async: flags=%b dout=%0h, required 0 0",
                     {data_valid, sop, eop, fifo_full, busy, ink_out, ovf, unf, abort}, dout); else passed++;
        total++; if (fifo_empty !== 1'b1) $display("FAIL clr_empty: got %b, required 1", fifo_empty); else passed++;
        step();
        clr = 1'b0;
        step();
        do_ink();
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL clr_first_ink: busy=%b, required 1", busy); else passed++;
    endtask

    initial begin
        clr = 1'b1; ink = 1'b0; data_en = 1'b0; start = 1'b0; mode = 1'b0;
        din = '0; l_stroke = '0;
        step(2);
        test_reset();
        step();
        clr = 1'b0;
        step();
        test_basic();
        test_start_rules();
        test_underrun();
        test_abort();
        test_overflow();
        test_full_rw();
        test_continuous();
        test_clr_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
